// File: rtl/aes_block_uart_tx.sv
// aes_block_uart_tx: queues whole cipher blocks and sends them byte by byte on an
// 8N1 UART transmitter.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   in_valid    block offered
//   in_ready    block FIFO not full (from registered state only)
//   in_block    cipher block, captured when in_valid & in_ready
//   tx          UART serial output, idle high, registered
//   busy        serialiser holds a block (LOAD through final STOP)
//   block_done  one-cycle pulse after the last frame of a block
//   fifo_level  number of blocks waiting in the FIFO
//
// Optional feature: define AES_TX_CHKSUM_EN to append one extra frame per block
// carrying the XOR of all block bytes.
module aes_block_uart_tx #(
    parameter int unsigned  CLK_FREQ   = 50_000_000,
    parameter int unsigned  BAUD_RATE  = 115200,
    parameter int unsigned  BLOCK_BITS = 128,
    parameter int unsigned  FIFO_DEPTH = 4,
    parameter bit           MSB_FIRST  = 1'b1,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_BITS-1:0] in_block,
    output logic                  tx,
    output logic                  busy,
    output logic                  block_done,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned NBYTES       = BLOCK_BITS / 8;
`ifdef AES_TX_CHKSUM_EN
    localparam int unsigned NFRAMES      = NBYTES + 1;
`else
    localparam int unsigned NFRAMES      = NBYTES;
`endif
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned IDX_W = $clog2(NFRAMES + 1);

    if (BLOCK_BITS == 0 || BLOCK_BITS % 8 != 0) begin : g_bad_block_bits
        $error("BLOCK_BITS must be a positive multiple of 8");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least 1");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_baud
        $error("BAUD_RATE must not exceed CLK_FREQ");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

    // ---------------- block FIFO ----------------
    logic [BLOCK_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  push, pop;
    state_e                state_q, state_d;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready   = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = in_valid & in_ready;
    assign pop        = (state_q == StIdle) && (level_q != '0);
    assign fifo_level = level_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_block;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
        end
    end

    // ---------------- serialiser ----------------
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLOCK_BITS-1:0] shift_q, shift_d, shifted;
    logic [7:0]            cur_q, cur_d, sel;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  baud_last;
`ifdef AES_TX_CHKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    // The shift register always presents the next byte to send at the same end.
    assign sel       = MSB_FIRST ? shift_q[BLOCK_BITS-1 -: 8] : shift_q[7:0];
    assign shifted   = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
    assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cur_d   = cur_q;
        done_d  = 1'b0;
`ifdef AES_TX_CHKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = StLoad;
                end
            end
            StLoad: begin
                idx_d   = '0;
                baud_d  = '0;
                cur_d   = sel;
                shift_d = shifted;
`ifdef AES_TX_CHKSUM_EN
                chk_d   = sel;
`endif
                state_d = StStart;
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q < IDX_W'(NBYTES - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        cur_d   = sel;
                        shift_d = shifted;
`ifdef AES_TX_CHKSUM_EN
                        chk_d   = chk_q ^ sel;
`endif
                        state_d = StStart;
`ifdef AES_TX_CHKSUM_EN
                    end else if (idx_q == IDX_W'(NBYTES - 1)) begin
                        // All data bytes are folded into chk_q by now.
                        idx_d   = idx_q + 1'b1;
                        cur_d   = chk_q;
                        state_d = StStart;
`endif
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // tx is registered from the next state so it changes on the same edge as the FSM.
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            cur_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef AES_TX_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cur_q   <= cur_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef AES_TX_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != StIdle);
    assign block_done = done_q;

endmodule

// File: doc/aes_block_uart_tx.md
Name: aes_block_uart_tx

Overview:
Parametrised successor to the single-block AES-to-UART path. It accepts whole cipher blocks over a valid/ready handshake and queues them in an internal block FIFO. Each block is serialised into bytes and sent on an integrated 8N1 UART transmitter. It sits between the AES core output and the board TX pin, and supports back-to-back blocks, configurable block width and byte order.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
BAUD_RATE, 115200, UART rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, truncated (434 at defaults)
BLOCK_BITS, 128, block width; must be a multiple of 8, otherwise elaboration error; NBYTES = BLOCK_BITS/8
FIFO_DEPTH, 4, number of queued blocks (>=1), excluding the block in the serialiser
MSB_FIRST, 1, 1: first byte sent = in_block[BLOCK_BITS-1 -: 8]; 0: first byte = in_block[7:0]

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  block offered
in_ready  out  1  block FIFO not full
in_block  in  BLOCK_BITS  cipher block, sampled when in_valid & in_ready
tx  out  1  UART serial output, idle high, registered
busy  out  1  high while the serialiser holds a block (LOAD through final STOP)
block_done  out  1  one-cycle pulse when a block's last frame completes
fifo_level  out  $clog2(FIFO_DEPTH+1)  queued blocks in the FIFO

Behaviour:
- Clocking and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: tx=1, in_ready=1 (after reset deasserts), busy=0, block_done=0, fifo_level=0. FIFO pointers, FSM, baud counter and byte counter are cleared.
- FIFO:
  - Push when in_valid & in_ready. in_ready = (fifo_level != FIFO_DEPTH), computed from registered state only.
  - A push while full is impossible, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; non-power-of-2 depths must work.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty, pop the head block into the shift register and go to LOAD.
  - LOAD: byte_idx=0, select current byte per MSB_FIRST, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx < NBYTES-1: increment, select next byte, go to START with no idle gap. Otherwise pulse block_done on the last stop cycle and go to IDLE.
- Back-to-back blocks: the next block's LOAD directly follows IDLE. Exactly one idle cycle (tx=1) plus the LOAD cycle separate blocks.
- Latency: handshake at edge k with empty FIFO and IDLE → popped at k+1, LOAD at k+1, tx falls at edge k+2.
- Timing: frame = 10*CLKS_PER_BIT cycles. Block = NBYTES frames.
- Input holding: in_block is captured into the FIFO. Later changes to in_block have no effect on queued or in-flight data.
- Reset mid-frame: tx returns to 1 on the next edge, FIFO contents are discarded, and no block_done is emitted.
- busy is 1 from the LOAD cycle through the final STOP cycle.

Optional Feature:
Macro AES_TX_CHKSUM_EN.
- Defined: after the NBYTES data frames of each block, one extra frame carries the XOR of all NBYTES bytes. block_done pulses at the end of the checksum frame's stop bit. Block duration = (NBYTES+1) frames.
- Undefined: no checksum logic; block duration = NBYTES frames.

Test Plan:
- Single block, defaults, in_block=128'hd30216c83d902e5090291c9d378ffc08 → tx low 2 cycles after handshake; decoded bytes d3,02,16,…,8f,fc,08. block_done pulses once, 16*4340+2 cycles after the handshake edge.
- MSB_FIRST=0, same block → byte sequence 08,fc,8f,…,02,d3.
- Backpressure, FIFO_DEPTH=4: push 6 blocks back-to-back → blocks 1–5 accepted (1 in serialiser, 4 queued, fifo_level=4) and in_ready=0 on the 6th. After block 1's block_done, in_ready returns to 1 and block 6 is accepted. All 6 blocks are transmitted in order with exactly 1 idle cycle between blocks.
- Simultaneous push/pop at fifo_level=2 → fifo_level stays 2.
- Reset asserted mid-DATA of byte 5 → tx=1 next cycle, fifo_level=0, busy=0, no block_done. A new block after reset transmits correctly from byte 0.
- AES_TX_CHKSUM_EN defined, same block as the first test → 17 frames, 17th byte = 0xa8, block_done after 17*4340+2 cycles.
- BLOCK_BITS=64, BAUD_RATE=1_000_000 (CLKS_PER_BIT=50), in_block=64'h0123456789abcdef → bytes 01…ef, each bit 50 cycles wide.
